// File: rtl/pipo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipo_arbiter
//  Purpose  : Four-requester round-robin arbiter feeding a single shared
//             holding register with a valid/ready output port. The register
//             can be drained and reloaded on the same edge, so the port
//             sustains one word per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module pipo_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_src,
  output logic               busy
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [1:0]       src_q,   src_d;
  logic [1:0]       last_q,  last_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             accept_open;
  logic             grant_en;

  // Round-robin search: start one past the last winner and wrap around.
  always_comb begin
    logic [1:0] cand;
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Grant is combinational; the register can take a word when empty or when
  // the current word leaves on this same edge. Reset suppresses any grant.
  always_comb begin
    accept_open = (state_q == ST_EMPTY) || out_ready;
    grant_en    = accept_open && win_found && !reset;
    req_ready   = grant_en ? (4'b0001 << win_idx) : 4'b0000;
  end

  // Next-state: load on grant, drain to EMPTY when consumed without a refill.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    if (grant_en) begin
      state_d = ST_FULL;
      data_d  = req_data[win_idx*WIDTH +: WIDTH];
      src_d   = win_idx;
      last_d  = win_idx;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers; last_q resets to 3 so requester 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  // Output mapping.
  always_comb begin
    out_data  = data_q;
    out_valid = (state_q == ST_FULL);
    out_src   = src_q;
    busy      = (state_q == ST_FULL);
  end

endmodule
`default_nettype wire

// File: tb/tb_pipo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipo_arbiter
//  Purpose  : Self-checking bench for pipo_arbiter against a behavioural
//             model of the holding register and round-robin priority.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipo_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_data;
  logic [3:0]         req_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_src;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  bit         m_full;
  bit [7:0]   m_data;
  int         m_src;
  int         m_last;
  bit [7:0]   sb_q[$];

  pipo_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_full = 1'b0;
    m_data = 8'h00;
    m_src  = 0;
    m_last = 3;
  endfunction

  // Winner index from the model, or -1 when nothing may be granted.
  function automatic int model_winner(input logic [3:0] v, input logic rdy, input logic rst);
    if (rst) return -1;
    if (m_full && !rdy) return -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_grant(input logic [3:0] v, input logic rdy, input logic rst);
    int w;
    w = model_winner(v, rdy, rst);
    return (w < 0) ? 4'b0000 : 4'(1 << w);
  endfunction

  // Advance the model across one rising edge with the current inputs.
  function automatic void model_edge(input logic [3:0] v, input logic [31:0] d, input logic rdy);
    int w;
    w = model_winner(v, rdy, 1'b0);
    if (w >= 0) begin
      m_data = d[w*8 +: 8];
      m_src  = w;
      m_last = w;
      m_full = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
  endfunction

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic rdy);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    model_edge(req_valid, req_data, out_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b busy=%b data=%h src=%0d, required 0/0/00/0",
               out_valid, busy, out_data, out_src);
    end
    n_vec++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ready: req_ready=%b, required 0000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    reset     = 1'b0;
  endtask

  task automatic test_single_load();
    drive(4'b0001, 32'h000000A5, 1'b0);
    n_vec++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL single_grant: req_ready=%b, required 0001", req_ready);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd0) begin
        n_err++;
        $display("FAIL single_hold[%0d]: valid=%b busy=%b data=%h src=%0d, required 1/1/a5/0",
                 c, out_valid, busy, out_data, out_src);
      end
      drive(4'b0000, 32'h0, 1'b0);
      n_vec++;
      if (req_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL single_stall_ready[%0d]: req_ready=%b, required 0000", c, req_ready);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 32'h13121110, 1'b1);
      exp_g = model_grant(req_valid, out_ready, reset);
      n_vec++;
      if (req_ready !== exp_g) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: req_ready=%b, required %b", c, req_ready, exp_g);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== m_data || out_src !== 2'(m_src)) begin
        n_err++;
        $display("FAIL rr_out[%0d]: valid=%b data=%h src=%0d, required 1/%h/%0d",
                 c, out_valid, out_data, out_src, m_data, m_src);
      end
    end
  endtask

  task automatic test_drain();
    bit [7:0] held;
    held = m_data;
    drive(4'b0000, 32'h0, 1'b1);
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== held) begin
      n_err++;
      $display("FAIL drain: valid=%b busy=%b data=%h, required 0/0/%h", out_valid, busy, out_data, held);
    end
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 32'h0, c[0]);
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || out_data !== held) begin
        n_err++;
        $display("FAIL empty_ready_ignored[%0d]: valid=%b data=%h, required 0/%h", c, out_valid, out_data, held);
      end
    end
  endtask

  task automatic test_stall();
    bit [7:0] held;
    int       exp_w;
    drive(4'b1111, 32'h44332211, 1'b0);
    tick();
    held = m_data;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 32'h44332211, 1'b0);
      n_vec++;
      if (req_ready !== 4'b0000 || out_data !== held || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL stall[%0d]: req_ready=%b data=%h valid=%b, required 0000/%h/1",
                 c, req_ready, out_data, out_valid, held);
      end
      tick();
    end
    drive(4'b1111, 32'h44332211, 1'b1);
    exp_w = (m_last + 1) % 4;
    n_vec++;
    if (req_ready !== 4'(1 << exp_w)) begin
      n_err++;
      $display("FAIL stall_release: req_ready=%b, required grant to %0d", req_ready, exp_w);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(4'b0100, 32'h003C0000, 1'b1);
    tick();
    n_vec++;
    if (out_data !== 8'h3C || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL preload_3c: data=%h valid=%b, required 3c/1", out_data, out_valid);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_vec++;
    if (out_data !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: data=%h valid=%b busy=%b, required 00/0/0", out_data, out_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b1010;
    req_data  = 32'h55443322;
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL post_reset_grant: req_ready=%b, required 0010", req_ready);
    end
    tick();
    n_vec++;
    if (out_src !== 2'd1 || out_data !== 8'h33) begin
      n_err++;
      $display("FAIL post_reset_out: src=%0d data=%h, required 1/33", out_src, out_data);
    end
  endtask

  task automatic test_random();
    logic [3:0]  pend_v;
    logic [31:0] pend_d;
    logic [3:0]  exp_g;
    int          w;
    pend_v = 4'b0000;
    pend_d = 32'h0;
    sb_q.delete();
    if (m_full) sb_q.push_back(m_data);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
          pend_v[i]         = 1'b1;
          pend_d[i*8 +: 8]  = 8'($urandom);
        end
      end
      drive(pend_v, pend_d, 1'($urandom_range(0, 1)));
      exp_g = model_grant(req_valid, out_ready, reset);
      n_vec++;
      if (req_ready !== exp_g || $countones(req_ready) > 1) begin
        n_err++;
        $display("FAIL rand_grant[%0d]: req_ready=%b, required %b", c, req_ready, exp_g);
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_unexpected[%0d]: data=%h consumed, required no word", c, out_data);
        end else if (out_data !== sb_q[0]) begin
          n_err++;
          $display("FAIL rand_order[%0d]: data=%h, required %h", c, out_data, sb_q[0]);
          void'(sb_q.pop_front());
        end else begin
          void'(sb_q.pop_front());
        end
      end
      w = model_winner(req_valid, out_ready, reset);
      if (w >= 0) begin
        sb_q.push_back(pend_d[w*8 +: 8]);
        pend_v[w] = 1'b0;
      end
      tick();
      n_vec++;
      if (out_valid !== m_full || (m_full && (out_data !== m_data || out_src !== 2'(m_src)))) begin
        n_err++;
        $display("FAIL rand_state[%0d]: valid=%b data=%h src=%0d, required %b/%h/%0d",
                 c, out_valid, out_data, out_src, m_full, m_data, m_src);
      end
    end
    n_vec++;
    if (sb_q.size() != (m_full ? 1 : 0)) begin
      n_err++;
      $display("FAIL rand_leftover: %0d words outstanding, required %0d", sb_q.size(), m_full ? 1 : 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 4'b0000;
    req_data  = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_load();
    test_round_robin();
    test_drain();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipo_arbiter.md
PIPO_ARBITER -- requirements
Module: pipo_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the shared holding register.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  4  per-requester load request; bit i belongs to requester i.
REQ-005 req_data  input  4*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-006 req_ready  output  4  one-hot grant; bit i high means requester i's data is captured at this edge.
REQ-007 out_data  output  WIDTH  contents of the shared holding register.
REQ-008 out_valid  output  1  holding register contains unconsumed data.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle when out_valid=1.
REQ-010 out_src  output  2  index of the requester whose data is in the register.
REQ-011 busy  output  1  equals out_valid; provided for status polling.

Function
REQ-012 Two states SHALL exist: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 Accept window SHALL be open when state=EMPTY, or state=FULL and out_ready=1.
REQ-014 With the window open and any req_valid set, exactly one req_ready bit SHALL assert combinationally in that cycle; otherwise req_ready=0.
REQ-015 Grant selection SHALL be round-robin: search order starts at last_grant+1 mod 4 and wraps; first set req_valid bit in that order wins.
REQ-016 On a grant edge: holding register <= winner's req_data, out_src <= winner index, last_grant <= winner index, state <= FULL.
REQ-017 Latency SHALL be one cycle: data granted at edge k is on out_data with out_valid=1 in the cycle after edge k.
REQ-018 FULL with out_ready=1 and no req_valid: state <= EMPTY; out_data and out_src SHALL hold their last values.
REQ-019 FULL with out_ready=1 and a grant: the old word is consumed and the new word loaded on the same edge; state stays FULL (back-to-back throughput of one word per cycle).
REQ-020 FULL with out_ready=0: register, out_src and last_grant SHALL hold; req_ready=0.
REQ-021 last_grant SHALL change only on a grant edge.
REQ-022 req_ready SHALL never have more than one bit set.
REQ-023 Requesters SHALL hold req_valid and req_data stable until granted; the block does not buffer withdrawn requests.
REQ-024 out_ready while state=EMPTY SHALL be ignored.

Reset
REQ-025 On reset assertion, out_data SHALL be 0 and out_valid=0, out_src=0, busy=0, state=EMPTY, and last_grant=3 (requester 0 highest priority first), regardless of clock.
REQ-026 While reset is high, req_ready SHALL be 0.
REQ-027 Reset asserted mid-transfer SHALL discard any held word; no grant SHALL occur on the release edge unless req_valid is sampled after deassertion.

Verification
REQ-028 Reset, then req_valid=0001, data0=0xA5, out_ready=0 -> req_ready=0001 for one cycle; next cycle out_valid=1, out_data=0xA5, out_src=0; holds while out_ready=0.
REQ-029 All four requesting continuously, out_ready=1, data i=0x10+i -> grants 0,1,2,3,0,... one per cycle; out_data sequence 0x10,0x11,0x12,0x13,0x10.
REQ-030 FULL, out_ready=1, req_valid=0 -> next cycle out_valid=0, out_data unchanged; later out_ready pulses while EMPTY have no effect.
REQ-031 FULL with out_ready=0 for 5 cycles, req_valid=1111 -> req_ready=0 throughout, out_data stable; first out_ready=1 cycle grants last_grant+1.
REQ-032 Assert reset while FULL with out_data=0x3C -> out_data=0, out_valid=0 immediately (asynchronously); after release with req_valid=1010 -> requester 1 granted first.
REQ-033 Randomized valid/ready with scoreboard -> every granted word is seen exactly once on out_data in grant order; req_ready one-hot or zero every cycle.
